gate_test_sequencer: RTL and testbench

Self-checking sequencer for the lab's single-output logic gates: on `start` it drives every input vector of an N-input gate under test, waits a settle interval, samples the gate output, compares it with the expected function selected by `op_sel`, and reports a pass/fail verdict and mismatch count. It sits beside a gate instance (inverter, AND, OR, XOR) on the bench or FPGA top level. It replaces hand toggling of switches with an exhaustive, repeatable sweep.

---
 rtl/gate_test_sequencer.sv | 142 ++++++++++++++
 tb/tb_gate_test_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Exhaustive sweep tester for a single-output N-input logic gate. On start it
//   walks dut_in through 0 .. 2^N-1. Each vector is held for SETTLE cycles, then
//   dut_out is compared against the function picked by op_sel:
//   0 NOT(dut_in[0]), 1 AND, 2 OR, 3 XOR.
//   The result is reported as a mismatch count, the first failing vector and
//   a pass flag.
//
// Parameters
//   N       gate input count (1..8)
//   SETTLE  cycles a vector is held before dut_out is sampled (1..255)
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a sweep (only looked at in IDLE)
//   op_sel      expected function, latched when start is accepted
//   dut_out     output of the gate under test (assumed already synchronous)
//   dut_in      vector driven to the gate under test
//   busy        high in SETTLE/SAMPLE/DONE
//   done        one-cycle pulse in DONE
//   pass        last sweep had no mismatches; held until the next start
//   err_cnt     mismatch count of the current/last sweep
//   fail_vec    first mismatching vector, 0 if none
//
// Build option
//   GTS_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep and
//                        dut_in keeps the failing vector.

module gate_test_sequencer #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op_sel,
    input  logic         dut_out,
    output logic [N-1:0] dut_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] fail_vec
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [1:0] op_q;
    logic       expected;
    logic       mismatch;
    logic       last_vec;
    logic       stop;

    always_comb begin
        expected = 1'b0;
        case (op_q)
            2'd0:    expected = ~dut_in[0];
            2'd1:    expected = &dut_in;
            2'd2:    expected = |dut_in;
            default: expected = ^dut_in;
        endcase
    end

    assign mismatch = (dut_out != expected);
    assign last_vec = &dut_in;

`ifdef GTS_STOP_ON_FAIL_EN
    // Any mismatch here is the first one: an earlier one would have ended the sweep.
    assign stop = last_vec | mismatch;
`else
    assign stop = last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = stop ? S_DONE : S_SETTLE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            dut_in   <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op_sel;
                        dut_in   <= '0;
                        cnt      <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) cnt <= '0;
                    else                    cnt <= cnt + 8'd1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + (N+1)'(1);
                        if (err_cnt == '0) fail_vec <= dut_in;
                    end
                    // On the last vector (or a stopping mismatch) dut_in holds.
                    if (!stop) dut_in <= dut_in + N'(1);
                end
                S_DONE: pass <= (err_cnt == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer. Four instances with different N,
// SETTLE and attached gate models share clk/rst_n; each has its own start.
//   u1: N=1 SETTLE=1, op NOT, correct inverter
//   u2: N=2 SETTLE=3, op AND, gate is OR   (mismatch at vectors 1,2)
//   u3: N=3 SETTLE=1, op XOR, output stuck at 0
//   u4: N=2 SETTLE=1, op OR, correct OR gate (also start/op_sel/reset tests)

module tb_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] st;
    logic [1:0] op1, op2, op3, op4;

    logic [0:0] din1;  logic dout1, busy1, done1, pass1; logic [1:0] err1; logic [0:0] fv1;
    logic [1:0] din2;  logic dout2, busy2, done2, pass2; logic [2:0] err2; logic [1:0] fv2;
    logic [2:0] din3;  logic dout3, busy3, done3, pass3; logic [3:0] err3; logic [2:0] fv3;
    logic [1:0] din4;  logic dout4, busy4, done4, pass4; logic [2:0] err4; logic [1:0] fv4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dout1 = ~din1[0];
    assign dout2 = |din2;
    assign dout3 = 1'b0;
    assign dout4 = |din4;

    wire [3:0] done_all = {done4, done3, done2, done1};

    gate_test_sequencer #(.N(1), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .op_sel(op1), .dut_out(dout1),
        .dut_in(din1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1));
    gate_test_sequencer #(.N(2), .SETTLE(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .op_sel(op2), .dut_out(dout2),
        .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2));
    gate_test_sequencer #(.N(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .op_sel(op3), .dut_out(dout3),
        .dut_in(din3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .fail_vec(fv3));
    gate_test_sequencer #(.N(2), .SETTLE(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .op_sel(op4), .dut_out(dout4),
        .dut_in(din4), .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .fail_vec(fv4));

`ifdef GTS_STOP_ON_FAIL_EN
    localparam int T3_LEN = 4;   // vector 0 ok, vector 1 fails -> DONE
    localparam int T3_ERR = 1;
    localparam int T3_DIN = 1;
`else
    localparam int T3_LEN = 16;  // 8 vectors * 2 cycles
    localparam int T3_ERR = 4;   // XOR is 1 at 1,2,4,7
    localparam int T3_DIN = 7;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns on the negedge just after the accepting edge.
    task automatic start_pulse(input int idx);
        @(negedge clk);
        st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
    endtask

    // Counts negedges until done is seen; a missing done is a failed comparison.
    task automatic wait_done(input int idx, output int cyc);
        cyc = 0;
        while (!done_all[idx] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done_all[idx]), 32'd1);
    endtask

    initial begin
        int cyc, bc;
        logic seen;
        rst_n = 1'b0;
        st    = '0;
        op1 = 2'd0; op2 = 2'd1; op3 = 2'd3; op4 = 2'd2;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_pass", 32'(pass4), 0);
        chk("rst_err",  32'(err4),  0);
        chk("rst_fv",   32'(fv4),   0);
        chk("rst_din",  32'(din4),  0);
        rst_n = 1'b1;

        // T1: N=1 inverter, 2 vectors * 2 cycles
        start_pulse(0);
        chk("t1_busy", 32'(busy1), 1);
        chk("t1_din0", 32'(din1), 0);
        wait_done(0, cyc);
        chk("t1_len", cyc, 4);
        chk("t1_err", 32'(err1), 0);
        chk("t1_fv",  32'(fv1),  0);
        @(negedge clk);
        chk("t1_pass", 32'(pass1), 1);
        chk("t1_idle", 32'(busy1), 0);
        chk("t1_din_hold", 32'(din1), 1);

        // T2: AND expected, OR gate
        start_pulse(1);
        wait_done(1, cyc);
        chk("t2_len", cyc, 16);
        chk("t2_err", 32'(err2), 2);
        chk("t2_fv",  32'(fv2),  1);
        @(negedge clk);
        chk("t2_pass", 32'(pass2), 0);

        // T3: XOR expected, stuck-at-0
        start_pulse(2);
        wait_done(2, cyc);
        chk("t3_len", cyc, T3_LEN);
        chk("t3_err", 32'(err3), T3_ERR);
        chk("t3_fv",  32'(fv3),  1);
        chk("t3_din", 32'(din3), T3_DIN);
        @(negedge clk);
        chk("t3_pass", 32'(pass3), 0);

        // T4: correct OR, busy exactly 9 cycles
        start_pulse(3);
        bc = 0;
        while (busy4 && bc < 50) begin
            bc++;
            @(negedge clk);
        end
        chk("t4_busy_len", bc, 9);
        chk("t4_pass", 32'(pass4), 1);
        chk("t4_err",  32'(err4),  0);

        // T5: start re-pulsed and op_sel changed mid-sweep
        start_pulse(3);
        repeat (3) @(negedge clk);
        st[3] = 1'b1;
        op4   = 2'd1;
        @(negedge clk);
        st[3] = 1'b0;
        wait_done(3, cyc);
        chk("t5_len", cyc, 4);
        chk("t5_err", 32'(err4), 0);
        chk("t5_fv",  32'(fv4),  0);
        @(negedge clk);
        chk("t5_pass", 32'(pass4), 1);
        op4 = 2'd2;

        // T6: start held high on u3 -> back-to-back sweeps
        @(negedge clk);
        st[2] = 1'b1;
        @(negedge clk);
        wait_done(2, cyc);
        chk("t6a_len", cyc, T3_LEN);
        chk("t6a_err", 32'(err3), T3_ERR);
        @(negedge clk);
        chk("t6_gap_busy", 32'(busy3), 0);
        @(negedge clk);
        chk("t6b_busy", 32'(busy3), 1);
        chk("t6b_err_clr", 32'(err3), 0);
        chk("t6b_din", 32'(din3), 0);
        st[2] = 1'b0;
        wait_done(2, cyc);
        chk("t6b_len", cyc, T3_LEN);
        chk("t6b_err", 32'(err3), T3_ERR);
        @(negedge clk);

        // T7: async reset during SETTLE of vector 2 (pass4 is 1 beforehand)
        start_pulse(3);
        repeat (4) @(negedge clk);
        chk("t7_pre_din", 32'(din4), 2);
        rst_n = 1'b0;
        #1;
        chk("t7_busy", 32'(busy4), 0);
        chk("t7_din",  32'(din4),  0);
        chk("t7_pass", 32'(pass4), 0);
        chk("t7_err",  32'(err4),  0);
        chk("t7_done", 32'(done4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
        end
        chk("t7_no_done", 32'(seen), 0);
        start_pulse(3);
        wait_done(3, cyc);
        chk("t7_len", cyc, 8);
        chk("t7_err2", 32'(err4), 0);
        @(negedge clk);
        chk("t7_pass2", 32'(pass4), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
